key_debounce_led: RTL and testbench

KEY_DEBOUNCE_LED -- requirements
Module: key_debounce_led

---
 rtl/key_debounce_led.sv | 209 ++++++++++++++++++++
 tb/tb_key_debounce_led.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_led.sv
// key_debounce_led
//   Debounces KEY_NUM active-low keys and derives press / release / long-press
//   events. Short presses toggle led[i]. Long presses toggle led[i+KEY_NUM].
//   LEDs are active-low.
//
//   Optional feature: define KEY_LONG_PRESS_EN to build the LONG state, the
//   per-key hold counters and the long-press LEDs. Without it, key_long is
//   tied to 0, the upper LED half stays off, and each press toggles led[i].
//
// Ports
//   clk         : single clock, rising edge
//   rst         : asynchronous reset, active high
//   key_in      : raw keys, 0 = pressed
//   key_state   : debounced level, 1 = pressed
//   key_press   : one-clk pulse per key when a press is confirmed
//   key_release : one-clk pulse per key when a release is confirmed
//   key_long    : one-clk pulse per key when a long press is reached
//   led         : [KEY_NUM-1:0] short-press LEDs, [2*KEY_NUM-1:KEY_NUM] long-press LEDs
//
// Per-key FSM
//   state | meaning
//   IDLE  | released, waiting for a low sample
//   PCHK  | one low sample seen, confirming the press
//   HELD  | press confirmed, counting hold ticks
//   LONG  | long press reached, hold counter saturated
//   RCHK  | one high sample seen, confirming the release
module key_debounce_led #(
  parameter int KEY_NUM    = 4,
  parameter int TICK_MAX   = 500_000,
  parameter int LONG_TICKS = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_NUM-1:0]     key_in,
  output logic [KEY_NUM-1:0]     key_state,
  output logic [KEY_NUM-1:0]     key_press,
  output logic [KEY_NUM-1:0]     key_release,
  output logic [KEY_NUM-1:0]     key_long,
  output logic [2*KEY_NUM-1:0]   led
);

  localparam int TW = $clog2(TICK_MAX);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PCHK = 3'd1,
    HELD = 3'd2,
    RCHK = 3'd3
`ifdef KEY_LONG_PRESS_EN
    ,LONG = 3'd4
`endif
  } state_t;

  logic [KEY_NUM-1:0] sync1;
  logic [KEY_NUM-1:0] sync2;
  logic [KEY_NUM-1:0] key_low;
  logic [TW-1:0]      tick_cnt;
  logic               tick;
  state_t             state [KEY_NUM];

`ifdef KEY_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

  logic [HW-1:0]      hold [KEY_NUM];
  logic [KEY_NUM-1:0] from_long;   // origin of the pending release check
  logic [KEY_NUM-1:0] short_rel;   // qualifies key_release as a short press
`endif

  // Synchronizer resets to "released" so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign key_low = ~sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = (tick_cnt == TW'(TICK_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_press   <= '0;
      key_release <= '0;
`ifdef KEY_LONG_PRESS_EN
      key_long    <= '0;
      from_long   <= '0;
      short_rel   <= '0;
      for (int i = 0; i < KEY_NUM; i++) hold[i] <= '0;
`endif
      for (int i = 0; i < KEY_NUM; i++) state[i] <= IDLE;
    end else begin
      key_press   <= '0;
      key_release <= '0;
`ifdef KEY_LONG_PRESS_EN
      key_long    <= '0;
      short_rel   <= '0;
`endif
      if (tick) begin
        for (int i = 0; i < KEY_NUM; i++) begin
          case (state[i])
            IDLE: begin
              if (key_low[i]) state[i] <= PCHK;
            end
            PCHK: begin
              if (key_low[i]) begin
                state[i]     <= HELD;
                key_press[i] <= 1'b1;
`ifdef KEY_LONG_PRESS_EN
                hold[i]      <= '0;
`endif
              end else begin
                state[i] <= IDLE;
              end
            end
            HELD: begin
              if (key_low[i]) begin
`ifdef KEY_LONG_PRESS_EN
                // Threshold is checked before counting, so LONG is reached
                // LONG_TICKS ticks after the confirmed press.
                if (hold[i] == HOLD_LAST) begin
                  state[i]    <= LONG;
                  key_long[i] <= 1'b1;
                end else begin
                  hold[i] <= hold[i] + HW'(1);
                end
`endif
              end else begin
                state[i] <= RCHK;
`ifdef KEY_LONG_PRESS_EN
                from_long[i] <= 1'b0;
`endif
              end
            end
`ifdef KEY_LONG_PRESS_EN
            LONG: begin
              // Hold counter stays at HOLD_LAST here: saturated, never wraps.
              if (!key_low[i]) begin
                state[i]     <= RCHK;
                from_long[i] <= 1'b1;
              end
            end
`endif
            RCHK: begin
              if (key_low[i]) begin
`ifdef KEY_LONG_PRESS_EN
                state[i] <= from_long[i] ? LONG : HELD;
`else
                state[i] <= HELD;
`endif
              end else begin
                state[i]       <= IDLE;
                key_release[i] <= 1'b1;
`ifdef KEY_LONG_PRESS_EN
                short_rel[i]   <= ~from_long[i];
`endif
              end
            end
            default: state[i] <= IDLE;
          endcase
        end
      end
    end
  end

`ifndef KEY_LONG_PRESS_EN
  assign key_long = '0;
`endif

  always_comb begin
    key_state = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      key_state[i] = (state[i] == HELD) || (state[i] == RCHK);
`ifdef KEY_LONG_PRESS_EN
      if (state[i] == LONG) key_state[i] = 1'b1;
`endif
    end
  end

  // LEDs react to the registered pulses, so they change one cycle after them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '1;
    end else begin
`ifdef KEY_LONG_PRESS_EN
      led[KEY_NUM-1:0]         <= led[KEY_NUM-1:0] ^ (key_release & short_rel);
      led[2*KEY_NUM-1:KEY_NUM] <= led[2*KEY_NUM-1:KEY_NUM] ^ key_long;
`else
      led[KEY_NUM-1:0]         <= led[KEY_NUM-1:0] ^ key_press;
      led[2*KEY_NUM-1:KEY_NUM] <= '1;
`endif
    end
  end

endmodule

// File: tb/tb_key_debounce_led.sv
// tb_key_debounce_led
//   Directed bench for key_debounce_led with KEY_NUM=4, TICK_MAX=4,
//   LONG_TICKS=3. Expected values are worked out by hand from the
//   key timing: each scenario starts from reset so the tick phase is fixed,
//   and every low window is a whole number of ticks long.
module tb_key_debounce_led;

  logic       clk;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;
  logic [7:0] led;

  int n_total = 0;
  int n_bad   = 0;

  key_debounce_led #(
    .KEY_NUM   (4),
    .TICK_MAX  (4),
    .LONG_TICKS(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .led        (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor: counts pulses, remembers when they happened and when each
  // LED bit last changed. Cleared while rst is high.
  int         cyc = 0;
  int         press_cnt [4];
  int         rel_cnt   [4];
  int         long_cnt  [4];
  int         press_cyc [4];
  int         rel_cyc   [4];
  int         long_cyc  [4];
  int         led_cyc   [8];
  int         wide_cnt = 0;
  logic [3:0] first_press;
  logic [3:0] prev_p, prev_r, prev_l;
  logic [7:0] led_prev;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
        press_cyc[i] = -100; rel_cyc[i] = -100; long_cyc[i] = -100;
      end
      for (int j = 0; j < 8; j++) led_cyc[j] = -100;
      first_press = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (key_press[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
        if (key_release[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
        if (key_long[i])    begin long_cnt[i]++;  long_cyc[i]  = cyc; end
      end
      for (int j = 0; j < 8; j++)
        if (led[j] != led_prev[j]) led_cyc[j] = cyc;
      if (key_press != 4'b0 && first_press == 4'b0) first_press = key_press;
      if (((key_press & prev_p) | (key_release & prev_r) | (key_long & prev_l)) != 4'b0)
        wide_cnt++;
    end
    prev_p   = key_press;
    prev_r   = key_release;
    prev_l   = key_long;
    led_prev = led;
    cyc++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All stimulus and checks happen 1 time unit after a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    step(4 * n);
  endtask

  task automatic reset_dut();
    rst    = 1'b1;
    key_in = 4'hF;
    step(3);
    rst = 1'b0;
  endtask

  int n;

  initial begin
    rst    = 1'b1;
    key_in = 4'hF;
    step(2);

    // Reset values
    check_val("rst_key_state", key_state,   4'h0);
    check_val("rst_press",     key_press,   4'h0);
    check_val("rst_release",   key_release, 4'h0);
    check_val("rst_long",      key_long,    4'h0);
    check_val("rst_led",       led,         8'hFF);

    // Short press on key 0: 4 low samples (press at 2nd, still short of long)
    reset_dut();
    key_in = 4'b1110;
    ticks(4);
    check_val("s1_key_state", key_state, 4'b0001);
    key_in = 4'b1111;
    ticks(5);
    check_val("s1_press_cnt", press_cnt[0], 1);
    check_val("s1_rel_cnt",   rel_cnt[0],   1);
    check_val("s1_long_cnt",  long_cnt[0],  0);
    check_val("s1_led",       led,          8'b1111_1110);
`ifdef KEY_LONG_PRESS_EN
    check_val("s1_led_after_rel", led_cyc[0] - rel_cyc[0], 1);
`else
    check_val("s1_led_after_press", led_cyc[0] - press_cyc[0], 1);
`endif

`ifdef KEY_LONG_PRESS_EN
    // Long press on key 1: 12 low samples
    reset_dut();
    key_in = 4'b1101;
    ticks(12);
    check_val("s2_key_state", key_state, 4'b0010);
    key_in = 4'b1111;
    ticks(5);
    check_val("s2_press_cnt", press_cnt[1], 1);
    check_val("s2_long_cnt",  long_cnt[1],  1);
    check_val("s2_rel_cnt",   rel_cnt[1],   1);
    check_val("s2_long_delay", long_cyc[1] - press_cyc[1], 12);
    check_val("s2_led_after_long", led_cyc[5] - long_cyc[1], 1);
    check_val("s2_led", led, 8'b1101_1111);
`else
    // Feature off: 12-tick hold on key 2 gives a press toggle, never a long
    reset_dut();
    key_in = 4'b1011;
    ticks(12);
    check_val("s6_key_state", key_state, 4'b0100);
    key_in = 4'b1111;
    ticks(5);
    check_val("s6_press_cnt", press_cnt[2], 1);
    check_val("s6_rel_cnt",   rel_cnt[2],   1);
    check_val("s6_long_cnt",  long_cnt[0] + long_cnt[1] + long_cnt[2] + long_cnt[3], 0);
    check_val("s6_led_after_press", led_cyc[2] - press_cyc[2], 1);
    check_val("s6_led", led, 8'b1111_1011);
`endif

    // Bounces: key 2 one tick low / one tick high, key 3 glitches shorter
    // than a tick, five times each
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      key_in = 4'b0011;
      step(2);
      key_in = 4'b1011;
      step(2);
      key_in = 4'b1111;
      step(4);
    end
    ticks(3);
    check_val("s3_press", press_cnt[2] + press_cnt[3], 0);
    check_val("s3_rel",   rel_cnt[2]   + rel_cnt[3],   0);
    check_val("s3_long",  long_cnt[2]  + long_cnt[3],  0);
    check_val("s3_led",   led, 8'hFF);

    // Keys 0 and 3 together for 4 ticks
    reset_dut();
    key_in = 4'b0110;
    ticks(4);
    check_val("s4_key_state", key_state, 4'b1001);
    key_in = 4'b1111;
    ticks(5);
    check_val("s4_first_press", first_press, 4'b1001);
    check_val("s4_press_cnt", press_cnt[0] + press_cnt[3], 2);
    check_val("s4_rel_cnt",   rel_cnt[0]   + rel_cnt[3],   2);
    check_val("s4_led", led, 8'b1111_0110);

    // Reset mid-press; key 0 stays held through and after reset
    reset_dut();
    key_in = 4'b1110;
    step(10);
    check_val("s5_held", key_state, 4'b0001);
    rst = 1'b1;
    #1;
    check_val("s5_async_state", key_state, 4'h0);
    step(1);
    check_val("s5_rst_press", key_press, 4'h0);
    check_val("s5_rst_led",   led,       8'hFF);
    step(2);
    rst = 1'b0;
    n = 0;
    while (key_press[0] !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    check_val("s5_repress_delay", n, 8);
    key_in = 4'b1111;
    ticks(5);
    check_val("s5_press_cnt", press_cnt[0], 1);
    check_val("s5_rel_cnt",   rel_cnt[0],   1);

    check_val("pulse_width", wide_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
